// File: rtl/iob_dma_mc.sv
`default_nettype none
// ============================================================================
// Module   : iob_dma_mc
// Purpose  : Multi-channel stream-to-memory DMA write engine. N_CH AXI-Stream
//            inputs, each with its own base address, length, busy and done
//            state, are interleaved onto one valid/ready memory write port by
//            a round-robin burst arbiter.
// Options  : IOB_DMA_MC_IRQ_EN - adds irq_mask_i / irq_o (registered
//            interrupt, the OR of masked done flags).
// Revision : 1.0 - initial release
// ============================================================================
module iob_dma_mc #(
    parameter int N_CH      = 4,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 16,
    parameter int BURST_LEN = 16,
    // Derived channel-index width; not meant to be overridden.
    parameter int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk_i,
    input  logic                   cke_i,
    input  logic                   arst_i,

    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic [CH_W-1:0]        cfg_ch_i,
    input  logic [ADDR_W-1:0]      cfg_addr_i,
    input  logic [LEN_W-1:0]       cfg_len_i,

    input  logic [N_CH*DATA_W-1:0] s_tdata_i,
    input  logic [N_CH-1:0]        s_tvalid_i,
    output logic [N_CH-1:0]        s_tready_o,

    output logic                   mem_valid_o,
    input  logic                   mem_ready_i,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic [DATA_W-1:0]      mem_data_o,
    output logic                   mem_last_o,

    output logic [N_CH-1:0]        busy_o,
    output logic [N_CH-1:0]        done_o,
`ifdef IOB_DMA_MC_IRQ_EN
    input  logic [N_CH-1:0]        irq_mask_i,
    output logic                   irq_o,
`endif
    input  logic [N_CH-1:0]        done_clr_i
);

    localparam int BC_W = $clog2(BURST_LEN + 1);
    localparam int STEP = DATA_W / 8;

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     grant_q, grant_d;
    logic [CH_W-1:0]     last_q,  last_d;
    logic [BC_W-1:0]     bc_q,    bc_d;
    logic [ADDR_W-1:0]   ptr_q [N_CH];
    logic [ADDR_W-1:0]   ptr_d [N_CH];
    logic [LEN_W-1:0]    rem_q [N_CH];
    logic [LEN_W-1:0]    rem_d [N_CH];
    logic [N_CH-1:0]     busy_q, busy_d;
    logic [N_CH-1:0]     done_q, done_d;

    logic                w_cfg_ready;
    logic                w_sel_valid;
    logic [DATA_W-1:0]   w_sel_data;
    logic [ADDR_W-1:0]   w_sel_ptr;
    logic [N_CH-1:0]     w_cand;
    logic                w_hit;
    logic [CH_W-1:0]     w_pick;
    logic [LEN_W-1:0]    w_pick_rem;
    logic [BC_W-1:0]     w_bc_load;

    assign w_cand      = busy_q & s_tvalid_i;
    assign cfg_ready_o = w_cfg_ready;
    assign mem_addr_o  = w_sel_ptr;
    assign mem_data_o  = w_sel_data;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

    // Config target readiness: a busy channel stalls its config (an index
    // beyond N_CH is never ready).
    always_comb begin
        w_cfg_ready = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (cfg_ch_i == CH_W'(k)) begin
                w_cfg_ready = ~busy_q[k];
            end
        end
    end

    // Granted-channel view: stream lane, valid and write pointer.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        w_sel_ptr   = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (grant_q == CH_W'(k)) begin
                w_sel_valid = s_tvalid_i[k];
                w_sel_data  = s_tdata_i[k*DATA_W +: DATA_W];
                w_sel_ptr   = ptr_q[k];
            end
        end
    end

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        w_hit      = 1'b0;
        w_pick     = '0;
        w_pick_rem = '0;
        for (int i = 1; i <= N_CH; i++) begin
            int idx;
            idx = (int'(last_q) + i) % N_CH;
            if (!w_hit && w_cand[idx]) begin
                w_hit      = 1'b1;
                w_pick     = CH_W'(idx);
                w_pick_rem = rem_q[idx];
            end
        end
        if (32'(w_pick_rem) >= 32'(BURST_LEN)) begin
            w_bc_load = BC_W'(BURST_LEN);
        end else begin
            w_bc_load = BC_W'(w_pick_rem);
        end
    end

    // Next-state logic: done clears, config loads, arbiter FSM and beat
    // bookkeeping, plus the memory/stream handshake outputs.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        bc_d        = bc_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        busy_d      = busy_q;
        mem_valid_o = 1'b0;
        mem_last_o  = 1'b0;
        s_tready_o  = '0;

        // Clears are applied first so any set below wins.
        done_d = done_q & ~done_clr_i;

        if (cfg_valid_i && w_cfg_ready) begin
            for (int k = 0; k < N_CH; k++) begin
                if (cfg_ch_i == CH_W'(k)) begin
                    ptr_d[k]  = cfg_addr_i;
                    rem_d[k]  = cfg_len_i;
                    done_d[k] = 1'b0;
                    if (cfg_len_i != '0) begin
                        busy_d[k] = 1'b1;
                    end else begin
                        done_d[k] = 1'b1;
                    end
                end
            end
        end

        case (state_q)
            ST_ARB: begin
                if (w_hit) begin
                    grant_d = w_pick;
                    bc_d    = w_bc_load;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                mem_valid_o = w_sel_valid;
                mem_last_o  = (bc_q == BC_W'(1));
                for (int k = 0; k < N_CH; k++) begin
                    if (grant_q == CH_W'(k)) begin
                        s_tready_o[k] = mem_ready_i;
                    end
                end
                if (w_sel_valid && mem_ready_i) begin
                    for (int k = 0; k < N_CH; k++) begin
                        if (grant_q == CH_W'(k)) begin
                            ptr_d[k] = ptr_q[k] + ADDR_W'(STEP);
                            rem_d[k] = rem_q[k] - LEN_W'(1);
                            if (rem_q[k] == LEN_W'(1)) begin
                                busy_d[k] = 1'b0;
                                done_d[k] = 1'b1;
                            end
                        end
                    end
                    bc_d = bc_q - BC_W'(1);
                    if (bc_q == BC_W'(1)) begin
                        last_d  = grant_q;
                        state_d = ST_ARB;
                    end
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // State registers; everything holds while the clock enable is low.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= ST_ARB;
            grant_q <= '0;
            last_q  <= CH_W'(N_CH - 1);
            bc_q    <= '0;
            busy_q  <= '0;
            done_q  <= '0;
            for (int k = 0; k < N_CH; k++) begin
                ptr_q[k] <= '0;
                rem_q[k] <= '0;
            end
        end else if (cke_i) begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            bc_q    <= bc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int k = 0; k < N_CH; k++) begin
                ptr_q[k] <= ptr_d[k];
                rem_q[k] <= rem_d[k];
            end
        end
    end

`ifdef IOB_DMA_MC_IRQ_EN
    logic irq_q;

    assign irq_o = irq_q;

    // Interrupt follows the masked done flags one cycle later.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            irq_q <= 1'b0;
        end else if (cke_i) begin
            irq_q <= |(done_q & irq_mask_i);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_iob_dma_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_dma_mc
// Purpose  : Directed self-checking bench for iob_dma_mc (N_CH=4, 32-bit
//            data/address, BURST_LEN=16). Stream lane k carries
//            {8'(k), 24-bit word index} so every beat identifies its source.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iob_dma_mc;

    localparam int N_CH = 4;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int LW   = 16;
    localparam int BL   = 16;

    logic            clk = 1'b0;
    logic            cke, arst;
    logic            cfg_valid, cfg_ready;
    logic [1:0]      cfg_ch;
    logic [AW-1:0]   cfg_addr;
    logic [LW-1:0]   cfg_len;
    logic [N_CH*DW-1:0] s_tdata;
    logic [N_CH-1:0] s_tvalid, s_tready;
    logic            mem_valid, mem_ready, mem_last;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data;
    logic [N_CH-1:0] busy, done, done_clr;
`ifdef IOB_DMA_MC_IRQ_EN
    logic [N_CH-1:0] irq_mask;
    logic            irq;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } beat_t;
    beat_t q[$];

    logic [23:0]     cnt [N_CH];
    logic [N_CH-1:0] hs = '0;

    iob_dma_mc #(
        .N_CH(N_CH), .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .BURST_LEN(BL)
    ) dut (
        .clk_i(clk), .cke_i(cke), .arst_i(arst),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_ch_i(cfg_ch),
        .cfg_addr_i(cfg_addr), .cfg_len_i(cfg_len),
        .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tready_o(s_tready),
        .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
        .mem_data_o(mem_data), .mem_last_o(mem_last),
        .busy_o(busy), .done_o(done),
`ifdef IOB_DMA_MC_IRQ_EN
        .irq_mask_i(irq_mask), .irq_o(irq),
`endif
        .done_clr_i(done_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Stream sources: each lane presents its own word index.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            s_tdata[k*DW +: DW] = {8'(k), cnt[k]};
        end
    end

    always @(negedge clk) hs = s_tvalid & s_tready;

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int k = 0; k < N_CH; k++) cnt[k] <= '0;
        end else if (cke) begin
            for (int k = 0; k < N_CH; k++) if (hs[k]) cnt[k] <= cnt[k] + 24'd1;
        end
    end

    // Memory-side beat recorder.
    always @(negedge clk) begin
        if (!arst && cke && mem_valid && mem_ready) begin
            q.push_back('{addr: mem_addr, data: mem_data, last: mem_last, cyc: cyc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst = 1'b1; cke = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_addr = '0;
        cfg_len = '0; s_tvalid = '0; mem_ready = 1'b1; done_clr = '0;
`ifdef IOB_DMA_MC_IRQ_EN
        irq_mask = '0;
`endif
        tick();
        tick();
        arst = 1'b0;
        q.delete();
    endtask

    task automatic do_cfg(input logic [1:0] ch, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        int n = 0;
        cfg_valid = 1'b1; cfg_ch = ch; cfg_addr = addr; cfg_len = len;
        #1;
        while (!cfg_ready && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL cfg_accept ch%0d: cfg_ready_o=%b after %0d cycles, required 1", ch, cfg_ready, n);
        end
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input logic [N_CH-1:0] mask, input int budget);
        int n = 0;
        while (((done & mask) != mask) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if ((done & mask) != mask) begin
            errors++;
            $display("FAIL wait_done: done_o=%b, required bits %b within %0d cycles", done, mask, budget);
        end
    endtask

    task automatic test_reset();
        arst = 1'b1; cke = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_addr = '0;
        cfg_len = '0; s_tvalid = 4'hF; mem_ready = 1'b1; done_clr = '0;
`ifdef IOB_DMA_MC_IRQ_EN
        irq_mask = '1;
`endif
        tick();
        checks++;
        if ({busy, done, s_tready, mem_valid, mem_last} !== 14'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b tready=%b valid=%b last=%b, required all 0",
                     busy, done, s_tready, mem_valid, mem_last);
        end
        arst = 1'b0;
        tick();
        checks++;
        if (cfg_ready !== 1'b1 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: cfg_ready=%b mem_valid=%b, required 1/0", cfg_ready, mem_valid);
        end
`ifdef IOB_DMA_MC_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: irq_o=%b, required 0", irq);
        end
`endif
        s_tvalid = '0;
    endtask

    task automatic test_single();
        logic pb, pd;
        int n = 0;
        do_reset();
        do_cfg(2'd0, 32'h1000, 16'd5);
        checks++;
        if (busy !== 4'b0001 || done !== 4'b0000) begin
            errors++;
            $display("FAIL single_busy: busy=%b done=%b, required 0001/0000", busy, done);
        end
        s_tvalid = 4'b0001;
        pb = busy[0]; pd = done[0];
        while (!done[0] && n < 50) begin
            pb = busy[0]; pd = done[0];
            tick();
            n++;
        end
        checks++;
        if (!(pb === 1'b1 && pd === 1'b0 && busy[0] === 1'b0 && done[0] === 1'b1)) begin
            errors++;
            $display("FAIL single_edge: before busy=%b done=%b after busy=%b done=%b, required 1,0 -> 0,1",
                     pb, pd, busy[0], done[0]);
        end
        repeat (5) tick();
        checks++;
        if (q.size() != 5 || s_tready !== 4'b0 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_count: beats=%0d tready=%b valid=%b, required 5/0000/0", q.size(), s_tready, mem_valid);
        end
        for (int i = 0; i < 5 && i < q.size(); i++) begin
            logic [AW-1:0] ea;
            logic [DW-1:0] ed;
            ea = 32'h1000 + 32'(4 * i);
            ed = {8'd0, 24'(i)};
            checks++;
            if (q[i].addr !== ea || q[i].data !== ed || q[i].last !== (i == 4)) begin
                errors++;
                $display("FAIL single_beat%0d: addr=%h data=%h last=%b, required %h %h %b",
                         i, q[i].addr, q[i].data, q[i].last, ea, ed, (i == 4));
            end
        end
        s_tvalid = '0;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int c = 0; c < 4; c++) do_cfg(2'(c), 32'(c * 32'h1000), 16'd40);
        s_tvalid = 4'hF;
        wait_done(4'hF, 400);
        checks++;
        if (q.size() != 160 || busy !== 4'b0) begin
            errors++;
            $display("FAIL rr_count: beats=%0d busy=%b, required 160/0000", q.size(), busy);
        end
        for (int p = 0; p < 160 && p < q.size(); p++) begin
            int b, j, sz, ch, off, ec;
            logic [AW-1:0] ea;
            logic [DW-1:0] ed;
            b   = (p < 128) ? p / 16 : 8 + (p - 128) / 8;
            j   = (p < 128) ? p % 16 : (p - 128) % 8;
            sz  = (p < 128) ? 16 : 8;
            ch  = b % 4;
            off = (b / 4) * 16 + j;
            ea  = 32'(ch * 32'h1000 + 4 * off);
            ed  = {8'(ch), 24'(off)};
            ec  = (p == 0) ? q[0].cyc : q[p-1].cyc + ((j == 0) ? 2 : 1);
            checks++;
            if (q[p].addr !== ea || q[p].data !== ed || q[p].last !== (j == sz - 1) || q[p].cyc != ec) begin
                errors++;
                $display("FAIL rr_beat%0d: addr=%h data=%h last=%b cyc=%0d, required %h %h %b %0d",
                         p, q[p].addr, q[p].data, q[p].last, q[p].cyc, ea, ed, (j == sz - 1), ec);
            end
        end
        s_tvalid = '0;
    endtask

    task automatic test_backpressure();
        int multi = 0;
        int n1 = 0, n3 = 0, prev_ch = -1;
        logic prev_last = 1'b1;
        do_reset();
        do_cfg(2'd1, 32'h2000, 16'd20);
        do_cfg(2'd3, 32'hFFFF_FFF8, 16'd4);
        for (int i = 0; i < 400; i++) begin
            mem_ready = i[0];
            s_tvalid  = {(i % 4 != 0), 1'b0, (i % 3 != 2), 1'b0};
            #1;
            if ($countones(s_tready) > 1) multi++;
            tick();
            if (done[1] && done[3]) break;
        end
        s_tvalid = '0;
        checks++;
        if (done !== 4'b1010 || q.size() != 24 || multi != 0) begin
            errors++;
            $display("FAIL bp_count: done=%b beats=%0d multi_tready=%0d, required 1010/24/0", done, q.size(), multi);
        end
        foreach (q[p]) begin
            int ch, nn;
            logic [AW-1:0] ea;
            logic el;
            ch = int'(q[p].data[31:24]);
            nn = (ch == 1) ? n1 : n3;
            ea = (ch == 1) ? 32'h2000 + 32'(4 * nn) : 32'hFFFF_FFF8 + 32'(4 * nn);
            el = (ch == 1) ? (nn == 15 || nn == 19) : (nn == 3);
            checks++;
            if ((ch != 1 && ch != 3) || q[p].addr !== ea || q[p].data[23:0] !== 24'(nn) ||
                q[p].last !== el || (!prev_last && ch != prev_ch)) begin
                errors++;
                $display("FAIL bp_beat%0d: ch=%0d addr=%h idx=%0d last=%b, required addr=%h idx=%0d last=%b no switch mid-burst",
                         p, ch, q[p].addr, q[p].data[23:0], q[p].last, ea, nn, el);
            end
            if (ch == 1) n1++; else n3++;
            prev_ch = ch;
            prev_last = q[p].last;
        end
    endtask

    task automatic test_cfg_corner();
        int n = 0;
        logic [AW-1:0] ea [5];
        ea = '{32'h700, 32'h704, 32'h708, 32'h800, 32'h804};
        do_reset();
        cke = 1'b0;
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_addr = 32'h500; cfg_len = 16'd0;
        tick();
        tick();
        checks++;
        if (done !== 4'b0000) begin
            errors++;
            $display("FAIL cke_freeze: done=%b, required 0000", done);
        end
        cke = 1'b1;
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (done !== 4'b0100 || busy !== 4'b0000) begin
            errors++;
            $display("FAIL len0: done=%b busy=%b, required 0100/0000", done, busy);
        end
        do_cfg(2'd1, 32'h700, 16'd3);
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_addr = 32'h800; cfg_len = 16'd2;
        #1;
        checks++;
        if (cfg_ready !== 1'b0 || busy !== 4'b0010) begin
            errors++;
            $display("FAIL cfg_busy: cfg_ready=%b busy=%b, required 0/0010", cfg_ready, busy);
        end
        repeat (3) tick();
        checks++;
        if (cfg_ready !== 1'b0 || busy[1] !== 1'b1 || q.size() != 0) begin
            errors++;
            $display("FAIL cfg_stall: cfg_ready=%b busy1=%b beats=%0d, required 0/1/0", cfg_ready, busy[1], q.size());
        end
        s_tvalid = 4'b0010;
        while (!cfg_ready && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (cfg_ready !== 1'b1 || done[1] !== 1'b1 || q.size() != 3) begin
            errors++;
            $display("FAIL cfg_release: cfg_ready=%b done1=%b beats=%0d, required 1/1/3", cfg_ready, done[1], q.size());
        end
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (busy[1] !== 1'b1 || done[1] !== 1'b0 || done[2] !== 1'b1) begin
            errors++;
            $display("FAIL cfg_reload: busy1=%b done1=%b done2=%b, required 1/0/1", busy[1], done[1], done[2]);
        end
        wait_done(4'b0010, 50);
        checks++;
        if (q.size() != 5) begin
            errors++;
            $display("FAIL cfg_total: beats=%0d, required 5", q.size());
        end
        for (int i = 0; i < 5 && i < q.size(); i++) begin
            checks++;
            if (q[i].addr !== ea[i] || q[i].data !== {8'd1, 24'(i)}) begin
                errors++;
                $display("FAIL cfg_beat%0d: addr=%h data=%h, required %h %h", i, q[i].addr, q[i].data, ea[i], {8'd1, 24'(i)});
            end
        end
        s_tvalid = '0;
    endtask

    task automatic test_done_contention();
        logic found = 1'b0;
        do_reset();
        do_cfg(2'd0, 32'h0, 16'd2);
        s_tvalid = 4'b0001;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (mem_valid && mem_last && mem_ready) begin
                found = 1'b1;
                break;
            end
        end
        done_clr = 4'b0001;
        tick();
        done_clr = 4'b0000;
        checks++;
        if (!found || done[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL set_over_clr: found=%b done0=%b busy0=%b, required 1/1/0", found, done[0], busy[0]);
        end
        done_clr = 4'b0001;
        tick();
        done_clr = 4'b0000;
        checks++;
        if (done[0] !== 1'b0) begin
            errors++;
            $display("FAIL done_clr: done0=%b, required 0", done[0]);
        end
        s_tvalid = '0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        do_cfg(2'd0, 32'h4000, 16'd10);
        s_tvalid = 4'b0001;
        while (q.size() < 3 && n < 50) begin
            tick();
            n++;
        end
        #2;
        arst = 1'b1;
        #1;
        checks++;
        if ({busy, done, s_tready, mem_valid, mem_last} !== 14'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b tready=%b valid=%b last=%b cfg_ready=%b, required all 0, ready 1",
                     busy, done, s_tready, mem_valid, mem_last, cfg_ready);
        end
        tick();
        arst = 1'b0;
        q.delete();
        do_cfg(2'd0, 32'h6000, 16'd2);
        wait_done(4'b0001, 50);
        checks++;
        if (q.size() != 2 || q[0].addr !== 32'h6000 || q[1].addr !== 32'h6004 ||
            q[0].data !== 32'h0 || q[1].data !== 32'h1 || q[1].last !== 1'b1) begin
            errors++;
            $display("FAIL reset_fresh: beats=%0d first=%h/%h, required 2 beats at 6000/6004 idx 0,1", q.size(),
                     (q.size() > 0) ? q[0].addr : 32'hx, (q.size() > 0) ? q[0].data : 32'hx);
        end
        s_tvalid = '0;
    endtask

`ifdef IOB_DMA_MC_IRQ_EN
    task automatic test_irq();
        int n = 0;
        do_reset();
        irq_mask = 4'b0010;
        do_cfg(2'd1, 32'h0, 16'd1);
        s_tvalid = 4'b0010;
        while (!done[1] && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (done[1] !== 1'b1 || irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_lag: done1=%b irq=%b, required 1/0", done[1], irq);
        end
        tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set: irq=%b, required 1", irq);
        end
        done_clr = 4'b0010;
        tick();
        done_clr = 4'b0000;
        tick();
        checks++;
        if (irq !== 1'b0 || done[1] !== 1'b0) begin
            errors++;
            $display("FAIL irq_clr: irq=%b done1=%b, required 0/0", irq, done[1]);
        end
        s_tvalid = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_cfg_corner();
        test_done_contention();
        test_reset_mid();
`ifdef IOB_DMA_MC_IRQ_EN
        test_irq();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
